// File: rtl/m_stage_dm.sv
// Memory-stage data memory: byte/half/word stores into a word array, combinational
// extended loads, load/ALU result mux toward M_W, store trace and sticky alignment flag.
module m_stage_dm #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WD,
    input  logic        M_MemWrite,
    input  logic        M_MemRead,
    input  logic [1:0]  M_width,
    input  logic        M_LoadSign,
    output logic [31:0] M_Reg_Data,
    output logic        St_Valid,
    output logic [31:0] St_PC,
    output logic [31:0] St_Addr,
    output logic [31:0] St_Data,
    output logic [3:0]  St_BE,
    output logic        Align_Err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             aligned;
    logic             legal;
    logic             store_commit;
    logic [3:0]       be;
    logic [31:0]      rd_word;
    logic [31:0]      wr_lane;
    logic [31:0]      merged;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      load_result;

    assign off      = M_Addr - ADDR_BASE;
    assign in_range = (off < LIMIT);
    // Index is forced to 0 when out of range so the array is never addressed past its end.
    assign idx      = in_range ? off[IDX_W+1:2] : '0;
    assign rd_word  = in_range ? mem[idx] : 32'h0;

    always_comb begin
        aligned = 1'b0;
        be      = 4'b0000;
        wr_lane = M_WD;
        case (M_width)
            2'b00: begin
                aligned = (off[1:0] == 2'b00);
                be      = 4'b1111;
                wr_lane = M_WD;
            end
            2'b01: begin
                aligned = ~off[0];
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{M_WD[15:0]}};
            end
            2'b10: begin
                aligned = 1'b1;
                be      = 4'b0001 << off[1:0];
                wr_lane = {4{M_WD[7:0]}};
            end
            default: begin
                aligned = 1'b0;
                be      = 4'b0000;
                wr_lane = M_WD;
            end
        endcase
    end

    assign legal        = aligned & in_range;
    assign store_commit = M_MemWrite & legal;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = be[gi] ? wr_lane[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        byte_sel = rd_word[7:0];
        case (off[1:0])
            2'b00:   byte_sel = rd_word[7:0];
            2'b01:   byte_sel = rd_word[15:8];
            2'b10:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
    end

    always_comb begin
        load_result = 32'h0;
        if (legal) begin
            case (M_width)
                2'b00:   load_result = rd_word;
                2'b01:   load_result = {{16{M_LoadSign & half_sel[15]}}, half_sel};
                2'b10:   load_result = {{24{M_LoadSign & byte_sel[7]}}, byte_sel};
                default: load_result = 32'h0;
            endcase
        end
    end

    assign M_Reg_Data = M_MemRead ? load_result : M_Addr;

    // Reads above use the pre-edge contents, so a same-cycle load+store is read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_commit) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            St_Valid <= 1'b0;
            St_PC    <= 32'h0;
            St_Addr  <= 32'h0;
            St_Data  <= 32'h0;
            St_BE    <= 4'b0000;
        end else begin
            St_Valid <= store_commit;
            if (store_commit) begin
                St_PC   <= M_PC;
                St_Addr <= {M_Addr[31:2], 2'b00};
                St_Data <= merged;
                St_BE   <= be;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Align_Err <= 1'b0;
        end else if ((M_MemRead | M_MemWrite) & ~legal) begin
            Align_Err <= 1'b1;
        end
    end

endmodule

// File: doc/m_stage_dm.md
Name: m_stage_dm

Overview:
- Memory-stage data-memory unit of the 5-stage MIPS pipeline; sits between the E_M and M_W pipeline registers.
- Performs word/half/byte stores into an internal word array and produces the sign- or zero-extended load result.
- Muxes load result vs. ALU result onto M_Reg_Data, which feeds M_W.
- Keeps a registered store-trace record and a sticky misalignment flag for the testbench.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array; word index = addr[13:2] when in range.
- ADDR_BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- M_PC  in  32  PC of instruction in M; used only for store trace
- M_Addr  in  32  byte address (ALU result from E)
- M_WD  in  32  store data, already forwarded
- M_MemWrite  in  1  store enable
- M_MemRead  in  1  load select; M_Reg_Data takes memory path when 1
- M_width  in  2  00 word, 01 half, 10 byte, 11 reserved
- M_LoadSign  in  1  1 = sign-extend half/byte loads, 0 = zero-extend
- M_Reg_Data  out  32  value forwarded to M_W (load data or M_Addr)
- St_Valid  out  1  registered: a store committed last cycle
- St_PC  out  32  registered PC of that store
- St_Addr  out  32  registered word-aligned address of that store
- St_Data  out  32  registered full word after merge
- St_BE  out  4  registered byte enables of that store
- Align_Err  out  1  sticky: a misaligned or out-of-range access occurred

Behaviour:
- Reset (async, active-high): every array word = 0, St_Valid = 0, St_PC/St_Addr/St_Data = 0, St_BE = 0, Align_Err = 0. Release on the next posedge resumes normal operation. Reset asserted mid-store: the store is lost and the array stays cleared.
- Offset: off = M_Addr - ADDR_BASE. In range iff off < 4*DEPTH_WORDS. Word index = off[13:2].
- Alignment:
  - word requires off[1:0] = 00.
  - half requires off[0] = 0.
  - byte is always aligned.
  - width 11 is treated as misaligned.
- Byte enables:
  - word: 1111.
  - half: 0011 when off[1] = 0, 1100 when off[1] = 1.
  - byte: 0001 << off[1:0].
  - Little-endian: byte 0 = bits [7:0].
- Store: when M_MemWrite = 1, aligned and in range, the array word is updated at posedge.
  - Only enabled bytes change.
  - Half data comes from M_WD[15:0] replicated into the enabled lanes; byte data from M_WD[7:0] replicated likewise.
- Store trace: same posedge as the store, St_Valid <= 1 and St_PC/St_Addr/St_Data/St_BE capture the store (St_Data = merged word). St_Valid <= 0 on any cycle without a committed store; the other St_* hold their values.
- Rejected store: misaligned or out-of-range store leaves the array unchanged, keeps St_Valid = 0, and sets Align_Err <= 1.
- Load (combinational, 0-cycle): rd = array[index], or 0 when out of range.
  - Selected half = rd[16*off[1] +: 16]; selected byte = rd[8*off[1:0] +: 8].
  - Extension per M_LoadSign.
  - Misaligned or out-of-range load returns 0 and sets Align_Err at the next posedge.
- M_Reg_Data = M_MemRead ? load_result : M_Addr.
- M_MemRead and M_MemWrite both 1: the load returns the pre-store contents (read-before-write), and the store commits at the edge.
- Store followed by a load to the same word next cycle sees the new data; no internal bypass is needed.
- Align_Err is cleared only by reset.

Test Plan:
- Reset with array preloaded via stores, then load word at 0x0 -> M_Reg_Data = 0, St_Valid = 0, Align_Err = 0.
- sw 0x12345678 @0x10, next cycle lw @0x10 -> 0x12345678. St_Valid pulses one cycle with St_Addr = 0x10, St_BE = 1111, St_PC = store PC.
- sb 0xAB @0x13 over 0x12345678, then lb @0x13 -> 0xFFFFFFAB, lbu -> 0x000000AB, lw -> 0xAB345678, St_BE = 1000.
- sh 0x8001 @0x12, then lh @0x12 -> 0xFFFF8001, lhu -> 0x00008001, lw @0x10 -> 0x80015678.
- sw @0x11 (misaligned) -> array unchanged, St_Valid = 0, Align_Err = 1 and stays 1 through later legal accesses until reset.
- lw @4*DEPTH_WORDS (out of range) -> M_Reg_Data = 0, Align_Err = 1. With M_MemRead = 0 and M_Addr = 0xDEAD0000 -> M_Reg_Data = 0xDEAD0000.
